// File: rtl/background_effect_generator_pkg.sv
// Shared types and colour constants for the background effect generator.
// The optional BG_EFFECT_RETRIGGER_EN build option lives in effect_timer.
package bg_effect_pkg;

  typedef logic [7:0]  rgb332_t;
  typedef logic [10:0] coord_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } effect_state_t;

  localparam rgb332_t BOOM_COLOR_A = 8'hE0;  // red
  localparam rgb332_t BOOM_COLOR_B = 8'hFC;  // yellow
  localparam rgb332_t ICE_COLOR    = 8'h5F;

endpackage

// File: rtl/background_effect_generator_if.sv
// Bundle of VGA timing, game events and effect outputs around the generator.
// There is no handshake: inputs are sampled every clock and outputs are valid
// every clock, one cycle after the pixel coordinates that produced them.
interface bg_effect_if;
  import bg_effect_pkg::*;

  logic    startOfFrame;
  coord_t  pixelX;
  coord_t  pixelY;
  logic    boomTrigger;
  logic    iceTrigger;
  logic    BoomDrawingRequest;
  rgb332_t BoomRGB;
  logic    IceDrawingRequest;
  rgb332_t IceRGB;
  logic    boomActive;
  logic    iceActive;

  modport master (
    output startOfFrame, pixelX, pixelY, boomTrigger, iceTrigger,
    input  BoomDrawingRequest, BoomRGB, IceDrawingRequest, IceRGB,
           boomActive, iceActive
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, boomTrigger, iceTrigger,
    output BoomDrawingRequest, BoomRGB, IceDrawingRequest, IceRGB,
           boomActive, iceActive
  );
endinterface

// File: rtl/background_effect_generator_effect_timer.sv
// Two-state effect FSM with a frame counter; lasts DURATION frames per trigger.
// BG_EFFECT_RETRIGGER_EN: a trigger while ACTIVE restarts the effect.
module effect_timer
  import bg_effect_pkg::*;
#(
  parameter int DURATION = 48,
  localparam int CW = $clog2(DURATION)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          trigger,
  input  logic          startOfFrame,
  output logic          active,
  output logic [CW-1:0] frameCnt
);

`ifdef BG_EFFECT_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  effect_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_frame;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_frame = startOfFrame && (cnt_q == CW'(DURATION - 1));
    case (state_q)
      IDLE: begin
        // A start-of-frame arriving with the trigger is not counted.
        if (trigger) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        // A trigger on the final frame edge always wins over the exit.
        if (trigger && (RETRIGGER || last_frame)) begin
          cnt_d = '0;
        end else if (startOfFrame) begin
          if (last_frame) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign active   = (state_q == ACTIVE);
  assign frameCnt = cnt_q;

endmodule

// File: rtl/background_effect_generator.sv
// Full-screen BOOM flash and growing ICE border, registered per pixel.
// Build option BG_EFFECT_RETRIGGER_EN is handled inside effect_timer.
module background_effect_generator
  import bg_effect_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BOOM_FRAMES = 48,
  parameter int ICE_FRAMES  = 120,
  parameter int FLASH_SHIFT = 2,
  parameter int ICE_STEP    = 4,
  parameter int ICE_BORDER  = 32
) (
  input  logic    clk,
  input  logic    resetN,
  input  logic    startOfFrame,
  input  coord_t  pixelX,
  input  coord_t  pixelY,
  input  logic    boomTrigger,
  input  logic    iceTrigger,
  output logic    BoomDrawingRequest,
  output rgb332_t BoomRGB,
  output logic    IceDrawingRequest,
  output rgb332_t IceRGB,
  output logic    boomActive,
  output logic    iceActive
);

  localparam int BCW = $clog2(BOOM_FRAMES);
  localparam int ICW = $clog2(ICE_FRAMES);

  logic           boom_active, ice_active;
  logic [BCW-1:0] boom_cnt;
  logic [ICW-1:0] ice_cnt;

  effect_timer #(.DURATION(BOOM_FRAMES)) u_boom_timer (
    .clk          (clk),
    .resetN       (resetN),
    .trigger      (boomTrigger),
    .startOfFrame (startOfFrame),
    .active       (boom_active),
    .frameCnt     (boom_cnt)
  );

  effect_timer #(.DURATION(ICE_FRAMES)) u_ice_timer (
    .clk          (clk),
    .resetN       (resetN),
    .trigger      (iceTrigger),
    .startOfFrame (startOfFrame),
    .active       (ice_active),
    .frameCnt     (ice_cnt)
  );

  logic    on_screen, boom_flash, ice_edge;
  logic [15:0] ice_prod;
  coord_t  ice_thick;
  logic    boom_req_d, boom_req_q, ice_req_d, ice_req_q;
  rgb332_t boom_rgb_d, boom_rgb_q, ice_rgb_d, ice_rgb_q;

  assign on_screen  = (pixelX < coord_t'(SCREEN_W)) && (pixelY < coord_t'(SCREEN_H));
  assign boom_flash = |((boom_cnt >> FLASH_SHIFT) & BCW'(1));

  // Wide product so the border saturates at ICE_BORDER instead of wrapping.
  assign ice_prod  = (16'(ice_cnt) + 16'd1) * 16'(ICE_STEP);
  assign ice_thick = (ice_prod > 16'(ICE_BORDER)) ? coord_t'(ICE_BORDER) : ice_prod[10:0];
  assign ice_edge  = (pixelX < ice_thick) || (pixelX >= coord_t'(SCREEN_W) - ice_thick) ||
                     (pixelY < ice_thick) || (pixelY >= coord_t'(SCREEN_H) - ice_thick);

  always_comb begin
    boom_req_d = boom_active && on_screen;
    boom_rgb_d = '0;
    if (boom_req_d) boom_rgb_d = boom_flash ? BOOM_COLOR_B : BOOM_COLOR_A;
    ice_req_d  = ice_active && on_screen && ice_edge;
    ice_rgb_d  = ice_req_d ? ICE_COLOR : '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      boom_req_q <= 1'b0;
      boom_rgb_q <= '0;
      ice_req_q  <= 1'b0;
      ice_rgb_q  <= '0;
    end else begin
      boom_req_q <= boom_req_d;
      boom_rgb_q <= boom_rgb_d;
      ice_req_q  <= ice_req_d;
      ice_rgb_q  <= ice_rgb_d;
    end
  end

  assign BoomDrawingRequest = boom_req_q;
  assign BoomRGB            = boom_rgb_q;
  assign IceDrawingRequest  = ice_req_q;
  assign IceRGB             = ice_rgb_q;
  assign boomActive         = boom_active;
  assign iceActive          = ice_active;

endmodule

// File: tb/tb_background_effect_generator.sv
// Self-checking bench for background_effect_generator: randomized pixels and
// triggers, a frames-remaining reference model and an expected-output queue.
module tb_background_effect_generator;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int BD = 48;
  localparam int ID = 120;

`ifdef BG_EFFECT_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN = 1'b0;

  bg_effect_if vif ();

  background_effect_generator dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (vif.startOfFrame),
    .pixelX             (vif.pixelX),
    .pixelY             (vif.pixelY),
    .boomTrigger        (vif.boomTrigger),
    .iceTrigger         (vif.iceTrigger),
    .BoomDrawingRequest (vif.BoomDrawingRequest),
    .BoomRGB            (vif.BoomRGB),
    .IceDrawingRequest  (vif.IceDrawingRequest),
    .IceRGB             (vif.IceRGB),
    .boomActive         (vif.boomActive),
    .iceActive          (vif.iceActive)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  // Model: frames left before each effect ends (0 = idle)
  int b_left = 0;
  int i_left = 0;

  int px[9] = '{100, 3, 4, 636, 31, 32, 700, 0, 320};
  int py[9] = '{100, 200, 200, 200, 200, 200, 10, 0, 240};

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic int next_left(int left, bit trig, bit sof, int dur);
    if (left == 0) return trig ? dur : 0;
    if (trig && (RETRIG || (sof && left == 1))) return dur;
    if (sof) return left - 1;
    return left;
  endfunction

  // Driver: apply one pixel cycle and queue the response expected after the edge
  task automatic step(input bit sof, input int x, input int y, input bit bt, input bit it);
    logic [19:0] e;
    bit breq, ireq;
    logic [7:0] brgb, irgb;
    int bf, iframe, thick;
    vif.startOfFrame = sof;
    vif.pixelX       = 11'(x);
    vif.pixelY       = 11'(y);
    vif.boomTrigger  = bt;
    vif.iceTrigger   = it;
    if (!resetN) begin
      e = '0;
      b_left = 0;
      i_left = 0;
    end else begin
      bf    = BD - b_left;
      breq  = (b_left != 0) && x < W && y < H;
      brgb  = breq ? (((bf / 4) % 2 == 1) ? 8'hFC : 8'hE0) : 8'h00;
      iframe = ID - i_left;
      thick = (iframe + 1) * 4;
      if (thick > 32) thick = 32;
      ireq  = (i_left != 0) && x < W && y < H &&
              (x < thick || x >= W - thick || y < thick || y >= H - thick);
      irgb  = ireq ? 8'h5F : 8'h00;
      b_left = next_left(b_left, bt, sof, BD);
      i_left = next_left(i_left, it, sof, ID);
      e = {b_left != 0, i_left != 0, breq, brgb, ireq, irgb};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    vif.startOfFrame = 1'b0;
    vif.boomTrigger  = 1'b0;
    vif.iceTrigger   = 1'b0;
  endtask

  // One short frame: start pulse, the fixed probe pixels, then random pixels
  task automatic frame(input bit bt, input bit it, input bit rnd);
    bit rb, ri;
    step(1'b1, $urandom_range(0, 799), $urandom_range(0, 524), bt, it);
    for (int k = 0; k < 9; k++) step(1'b0, px[k], py[k], 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      rb = rnd && ($urandom_range(0, 15) == 0);
      ri = rnd && ($urandom_range(0, 15) == 0);
      step(1'b0, $urandom_range(0, 799), $urandom_range(0, 524), rb, ri);
    end
  endtask

  // Async reset mid-effect: outputs must clear without waiting for a clock
  task automatic reset_check();
    logic [19:0] got;
    #2;
    resetN = 1'b0;
    #1;
    got = {vif.boomActive, vif.iceActive, vif.BoomDrawingRequest, vif.BoomRGB,
           vif.IceDrawingRequest, vif.IceRGB};
    checks++;
    if (got !== 20'h0) begin
      failures++;
      $display("FAIL async_reset actual=%h expected=00000", got);
    end
    b_left = 0;
    i_left = 0;
  endtask

  // Scoreboard monitor
  logic [19:0] mon_got, mon_exp;
  always begin
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {vif.boomActive, vif.iceActive, vif.BoomDrawingRequest, vif.BoomRGB,
                 vif.IceDrawingRequest, vif.IceRGB};
      checks++;
      if (mon_got !== mon_exp) begin
        failures++;
        $display("FAIL outputs t=%0t x=%0d y=%0d actual=%h expected=%h (bAct,iAct,bReq,bRGB,iReq,iRGB)",
                 $time, vif.pixelX, vif.pixelY, mon_got, mon_exp);
      end
    end
  end

  // Stimulus
  initial begin
    vif.startOfFrame = 1'b0;
    vif.pixelX = '0;
    vif.pixelY = '0;
    vif.boomTrigger = 1'b0;
    vif.iceTrigger = 1'b0;
    resetN = 1'b0;

    // Triggers under reset are ignored
    for (int k = 0; k < 4; k++) step(k == 2, $urandom_range(0, 799), $urandom_range(0, 524), 1'b1, 1'b1);
    resetN = 1'b1;
    repeat (3) frame(1'b0, 1'b0, 1'b0);

    // BOOM full run: trigger with the frame pulse, 48 counted frames
    frame(1'b1, 1'b0, 1'b0);
    repeat (50) frame(1'b0, 1'b0, 1'b0);

    // ICE growth and saturation
    frame(1'b0, 1'b1, 1'b0);
    repeat (22) frame(1'b0, 1'b0, 1'b0);
    reset_check();
    step(1'b0, 10, 10, 1'b0, 1'b0);
    resetN = 1'b1;

    // Both triggers in one cycle
    step(1'b0, 0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 320, 240, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);

    // Mid-effect trigger at frame 10
    for (int g = 0; g < 100 && (BD - b_left) < 10; g++) frame(1'b0, 1'b0, 1'b0);
    step(1'b0, 100, 100, 1'b1, 1'b1);
    for (int g = 0; g < 200 && b_left != 0; g++) frame(1'b0, 1'b0, 1'b0);

    // Trigger on the final frame edge restarts in both builds
    frame(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 100 && b_left > 1; g++) frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    repeat (2) frame(1'b0, 1'b0, 1'b0);

    // Reset mid-BOOM at frame 5, then stay idle without a trigger
    reset_check();
    step(1'b0, 100, 100, 1'b0, 1'b0);
    resetN = 1'b1;
    frame(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 20 && (BD - b_left) < 5; g++) frame(1'b0, 1'b0, 1'b0);
    reset_check();
    step(1'b1, 100, 100, 1'b0, 1'b0);
    resetN = 1'b1;
    repeat (3) frame(1'b0, 1'b0, 1'b0);

    // Random triggers and pixels
    repeat (60) frame($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'b1);

    #10;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
